// File: rtl/bram_arbiter.sv
// Two-port req/gnt arbiter sharing one single-port BRAM, with lock-based ownership.
// Define BRAM_ARB_RR_EN for round-robin in FREE; default is fixed priority (port 1 wins).
module bram_arbiter #(
   parameter int WIDTH     = 8,
   parameter int DEPTH_LOG = 10
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 p0_req,
   input  logic                 p0_we,
   input  logic                 p0_lock,
   input  logic [DEPTH_LOG-1:0] p0_addr,
   input  logic [WIDTH-1:0]     p0_wdata,
   output logic                 p0_gnt,
   output logic                 p0_rvalid,
   output logic [WIDTH-1:0]     p0_rdata,
   input  logic                 p1_req,
   input  logic                 p1_we,
   input  logic                 p1_lock,
   input  logic [DEPTH_LOG-1:0] p1_addr,
   input  logic [WIDTH-1:0]     p1_wdata,
   output logic                 p1_gnt,
   output logic                 p1_rvalid,
   output logic [WIDTH-1:0]     p1_rdata,
   output logic                 mem_en,
   output logic                 mem_we,
   output logic [DEPTH_LOG-1:0] mem_addr,
   output logic [WIDTH-1:0]     mem_din,
   input  logic [WIDTH-1:0]     mem_dout
);

   typedef enum logic [1:0] {FREE, OWN0, OWN1} state_t;

   state_t state;
   logic   sel0, sel1;
`ifdef BRAM_ARB_RR_EN
   logic   last;   // 1 = port 1 won the most recent grant from FREE
`endif

   // Grants are gated by rst_n so nothing is issued while reset is held.
   always_comb begin
      sel0 = 1'b0;
      sel1 = 1'b0;
      if (rst_n) begin
         case (state)
            FREE: begin
`ifdef BRAM_ARB_RR_EN
               if (p0_req && p1_req) begin
                  sel0 = last;
                  sel1 = !last;
               end else begin
                  sel0 = p0_req;
                  sel1 = p1_req;
               end
`else
               sel1 = p1_req;
               sel0 = p0_req && !p1_req;
`endif
            end
            OWN0:    sel0 = p0_req;
            OWN1:    sel1 = p1_req;
            default: ;
         endcase
      end
   end

   assign p0_gnt   = sel0;
   assign p1_gnt   = sel1;
   assign p0_rdata = mem_dout;
   assign p1_rdata = mem_dout;

   always_comb begin
      mem_en   = sel0 | sel1;
      mem_we   = 1'b0;
      mem_addr = '0;
      mem_din  = '0;
      if (sel0) begin
         mem_we   = p0_we;
         mem_addr = p0_addr;
         mem_din  = p0_wdata;
      end else if (sel1) begin
         mem_we   = p1_we;
         mem_addr = p1_addr;
         mem_din  = p1_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= FREE;
         p0_rvalid <= 1'b0;
         p1_rvalid <= 1'b0;
`ifdef BRAM_ARB_RR_EN
         last      <= 1'b1;
`endif
      end else begin
         p0_rvalid <= sel0 && !p0_we;
         p1_rvalid <= sel1 && !p1_we;
         case (state)
            FREE: begin
               if (sel0 && p0_lock)      state <= OWN0;
               else if (sel1 && p1_lock) state <= OWN1;
`ifdef BRAM_ARB_RR_EN
               if (sel0)      last <= 1'b0;
               else if (sel1) last <= 1'b1;
`endif
            end
            OWN0:    if (sel0 && !p0_lock) state <= FREE;
            OWN1:    if (sel1 && !p1_lock) state <= FREE;
            default: state <= FREE;
         endcase
      end
   end

endmodule
